// File: rtl/prog_cntr_ras.sv
// Program counter for the 32-bit core. Sequences increment/branch/jump/register-jump
// and call/return through a circular return-address stack with sticky over/underflow flags.
module prog_cntr_ras #(
   parameter int              AW        = 32,
   parameter int              JMP_W     = 26,
   parameter int              OFFS_W    = 16,
   parameter int              RAS_DEPTH = 4,
   parameter logic [AW-1:0]   RESET_VEC = '0,
   localparam int             PW        = $clog2(RAS_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              zero,
   input  logic              brnch,
   input  logic              jmp,
   input  logic              jr,
   input  logic              call,
   input  logic              ret,
   input  logic [JMP_W-1:0]  jmp_addr,
   input  logic [OFFS_W-1:0] brnch_offs,
   input  logic [AW-1:0]     reg_addr,
   output logic [AW-1:0]     pc,
   output logic [AW-1:0]     link,
   output logic [PW:0]       ras_cnt,
   output logic              ras_ovf,
   output logic              ras_unf
);

   logic [AW-1:0] pc_incr;
   logic [AW-1:0] offs_ext;
   logic [AW-1:0] ras_top;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0] sp;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;

   assign pc_incr  = pc + AW'(1);
   assign link     = pc_incr;
   assign offs_ext = AW'($signed(brnch_offs));
   assign ras_top  = ras_mem[sp - PW'(1)];
   assign empty    = (ras_cnt == '0);
   assign full     = (ras_cnt == (PW+1)'(RAS_DEPTH));

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      pc_next = pc_incr;
      pop     = 1'b0;
      push    = call && (jr || jmp) && !ret;
      if (ret) begin
         if (!empty) begin
            pc_next = ras_top;
            pop     = 1'b1;
         end
      end else if (jr) begin
         pc_next = reg_addr;
      end else if (jmp) begin
         pc_next = {pc_incr[AW-1:JMP_W], jmp_addr};
      end else if (brnch && zero) begin
         pc_next = pc_incr + offs_ext;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_VEC;
         sp      <= '0;
         ras_cnt <= '0;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else if (!stall) begin
         pc <= pc_next;
         if (push) begin
            sp <= sp + PW'(1);
            if (full) ras_ovf <= 1'b1;
            else      ras_cnt <= ras_cnt + (PW+1)'(1);
         end else if (pop) begin
            sp      <= sp - PW'(1);
            ras_cnt <= ras_cnt - (PW+1)'(1);
         end else if (ret && empty) begin
            ras_unf <= 1'b1;
         end
      end
   end

   // NOTE: stack storage is deliberately not reset; validity is tracked by ras_cnt alone.
   // When full, sp points at the oldest entry, so a push overwrites it naturally.
   always_ff @(posedge clk) begin
      if (!stall && push) ras_mem[sp] <= link;
   end

endmodule

// File: tb/tb_prog_cntr_ras.sv
// Directed self-checking bench for prog_cntr_ras with RESET_VEC=0x100 and a 4-deep stack.
module tb_prog_cntr_ras;

   localparam int AW = 32;
   localparam int JMP_W = 26;
   localparam int OFFS_W = 16;
   localparam int RAS_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, zero, brnch, jmp, jr, call, ret;
   logic [JMP_W-1:0]  jmp_addr;
   logic [OFFS_W-1:0] brnch_offs;
   logic [AW-1:0]     reg_addr;
   logic [AW-1:0]     pc, link;
   logic [2:0]        ras_cnt;
   logic              ras_ovf, ras_unf;

   int checks = 0;
   int errors = 0;

   prog_cntr_ras #(
      .AW(AW), .JMP_W(JMP_W), .OFFS_W(OFFS_W), .RAS_DEPTH(RAS_DEPTH), .RESET_VEC(32'h100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .zero(zero), .brnch(brnch), .jmp(jmp),
      .jr(jr), .call(call), .ret(ret), .jmp_addr(jmp_addr), .brnch_offs(brnch_offs),
      .reg_addr(reg_addr), .pc(pc), .link(link), .ras_cnt(ras_cnt),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      stall = 0; zero = 0; brnch = 0; jmp = 0; jr = 0; call = 0; ret = 0;
      jmp_addr = '0; brnch_offs = '0; reg_addr = '0;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      clr();
      jr = 1; reg_addr = a;
      step();
      clr();
   endtask

   initial begin
      clr();
      rst_n = 0;
      #12;
      check("rst_pc", pc, 32'h100);
      check("rst_cnt", 32'(ras_cnt), 0);
      check("rst_flags", {30'b0, ras_ovf, ras_unf}, 0);
      rst_n = 1;
      step(); step(); step();
      check("incr3", pc, 32'h103);
      step(); step();
      check("incr5", pc, 32'h105);
      #3 rst_n = 0;
      #1 check("async_rst", pc, 32'h100);
      #2 rst_n = 1;

      goto_pc(32'hFFFF_FFFF);
      check("pc_max", pc, 32'hFFFF_FFFF);
      check("link_wrap", link, 0);
      step();
      check("pc_wrap", pc, 0);

      goto_pc(32'h20);
      brnch = 1; zero = 1; brnch_offs = 16'hFFFE;
      step();
      check("br_neg", pc, 32'h1F);
      goto_pc(32'h20);
      brnch = 1; zero = 0; brnch_offs = 16'hFFFE;
      step();
      check("br_nottaken", pc, 32'h21);
      goto_pc(32'h20);
      brnch = 1; zero = 1; brnch_offs = 16'h0010;
      step();
      check("br_pos", pc, 32'h31);

      goto_pc(32'h0400_0010);
      jmp = 1; jmp_addr = 26'h0000123;
      step();
      check("jmp_abs", pc, 32'h0400_0123);
      jr = 1; reg_addr = 32'h500;
      step();
      check("jr_over_jmp", pc, 32'h500);

      goto_pc(32'h10);
      call = 1; jmp = 1; jmp_addr = 26'h80;
      step();
      check("call_pc", pc, 32'h80);
      check("call_cnt", 32'(ras_cnt), 1);
      clr(); ret = 1;
      step();
      check("ret_pc", pc, 32'h11);
      check("ret_cnt", 32'(ras_cnt), 0);

      clr(); call = 1; jmp = 1; jmp_addr = 26'h40; step();
      jmp_addr = 26'h60; step();
      jmp_addr = 26'h90; step();
      check("nest_pc", pc, 32'h90);
      check("nest_cnt", 32'(ras_cnt), 3);
      clr(); ret = 1;
      step(); check("nest_ret1", pc, 32'h61);
      step(); check("nest_ret2", pc, 32'h41);
      step(); check("nest_ret3", pc, 32'h12);
      check("nest_cnt0", 32'(ras_cnt), 0);
      check("nest_noflags", {30'b0, ras_ovf, ras_unf}, 0);

      goto_pc(32'h1);
      call = 1; jr = 1;
      reg_addr = 32'h2; step();
      reg_addr = 32'h3; step();
      reg_addr = 32'h4; step();
      reg_addr = 32'h5; step();
      check("pre_ovf_flag", 32'(ras_ovf), 0);
      check("full_cnt", 32'(ras_cnt), 4);
      reg_addr = 32'h40; step();
      check("ovf_pc", pc, 32'h40);
      check("ovf_flag", 32'(ras_ovf), 1);
      check("ovf_cnt", 32'(ras_cnt), 4);
      clr(); ret = 1;
      step(); check("pop1", pc, 32'h6);
      step(); check("pop2", pc, 32'h5);
      step(); check("pop3", pc, 32'h4);
      step(); check("pop4", pc, 32'h3);
      check("pop_cnt0", 32'(ras_cnt), 0);
      check("pre_unf_flag", 32'(ras_unf), 0);
      step();
      check("unf_pc", pc, 32'h4);
      check("unf_flag", 32'(ras_unf), 1);
      check("unf_cnt", 32'(ras_cnt), 0);

      clr(); call = 1; jmp = 1; jmp_addr = 26'h70;
      step();
      check("st_call_pc", pc, 32'h70);
      clr(); stall = 1; ret = 1; jmp = 1; jmp_addr = 26'h33;
      step(); step();
      check("stall_pc", pc, 32'h70);
      check("stall_cnt", 32'(ras_cnt), 1);
      check("stall_flags", {30'b0, ras_ovf, ras_unf}, 3);
      stall = 0;
      step();
      check("unstall_ret", pc, 32'h5);
      check("unstall_cnt", 32'(ras_cnt), 0);
      clr();

      #3 rst_n = 0;
      #1;
      check("rst2_pc", pc, 32'h100);
      check("rst2_flags", {30'b0, ras_ovf, ras_unf}, 0);
      rst_n = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_cntr_ras.md
Name: prog_cntr_ras

Overview:
Parametrised next-generation program counter for the 32-bit core. It keeps the existing sequencing modes: increment, conditional branch, absolute jump and register jump. It adds stall, call/return with a hardware return-address stack (RAS) of configurable depth, a configurable reset vector and overflow/underflow status. It sits between the decode/control unit and instruction memory and drives the fetch address every cycle.

Parameters:
AW, 32, PC/address width in bits; must be greater than JMP_W.
JMP_W, 26, width of absolute jump field.
OFFS_W, 16, width of signed branch offset; must be less than or equal to AW.
RAS_DEPTH, 4, return-address stack entries; power of two, 2..64.
RESET_VEC, 0, PC value after reset (AW bits).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS this cycle
zero  in  1  ALU zero flag
brnch  in  1  conditional branch instruction
jmp  in  1  absolute jump instruction
jr  in  1  register jump instruction
call  in  1  qualifies jmp/jr as a call: push link address
ret  in  1  return: pop RAS into PC
jmp_addr  in  JMP_W  absolute jump field
brnch_offs  in  OFFS_W  signed word offset
reg_addr  in  AW  register jump target
pc  out  AW  current fetch address (registered)
link  out  AW  pc+1 (combinational), for register-file link write
ras_cnt  out  clog2(RAS_DEPTH)+1  valid RAS entries
ras_ovf  out  1  sticky: push occurred when full
ras_unf  out  1  sticky: ret occurred when empty

Behaviour:
- Addressing is word-based: pc_incr = pc+1, modulo 2^AW. pc = all-ones wraps to 0.
- Reset is asynchronous on rst_n low: pc=RESET_VEC, ras_cnt=0, ras_ovf=0, ras_unf=0, stack pointer=0. Stack entry contents are don't-care. Leaving reset is synchronous to clk. Reset mid-call or mid-stall discards all state.
- stall=1: pc, stack, ras_cnt and flags hold. All other controls are ignored.
- Next-PC priority when not stalled, highest first:
  - ret: pc <= top of RAS; pop.
  - jr: pc <= reg_addr.
  - jmp: pc <= {pc_incr[AW-1:JMP_W], jmp_addr}.
  - brnch&zero: pc <= pc_incr + sign_extend(brnch_offs) to AW, modulo 2^AW.
  - otherwise: pc <= pc_incr.
- Push: when call=1 and (jr|jmp)=1 and ret=0, link (pc+1) is pushed in the same edge as the PC update. call alone, or call with ret, pushes nothing.
- Pop on empty (ras_cnt=0): pc <= pc_incr, ras_unf <= 1, ras_cnt stays 0.
- Push on full (ras_cnt=RAS_DEPTH): the circular buffer overwrites the oldest entry, ras_ovf <= 1 and ras_cnt stays RAS_DEPTH. Subsequent pops return the RAS_DEPTH most recent links, newest first.
- Flags clear only on reset.
- ras_cnt is +1 per push (saturating) and -1 per pop (floor 0). Push and pop never occur in the same cycle.
- Latency: controls sampled at edge N appear on pc after edge N. link is valid combinationally from pc.
- No X propagation: undefined control combinations resolve by the priority list above.

Test Plan:
- Reset/increment: rst_n low mid-cycle with RESET_VEC=0x100 -> pc=0x100 immediately. After release, 3 clocks -> 0x103. pc=0xFFFFFFFF + 1 clk -> 0.
- Branch: pc=0x20, brnch=1, zero=1, offs=0xFFFE -> pc=0x1F. zero=0 -> pc=0x21. Offs=0x0010 at pc=0x20 -> 0x31.
- Jump/jr priority: pc=0x0400_0010, jmp=1, jmp_addr=0x0000123 -> 0x0400_0123. jmp=1 and jr=1 with reg_addr=0x500 -> pc=0x500.
- Call/return: call+jmp at pc=0x10 to 0x80 -> pc=0x80, ras_cnt=1. ret -> pc=0x11, ras_cnt=0. Nested 3 calls return in LIFO order.
- Overflow/underflow (RAS_DEPTH=4): 5 calls from pcs 0x1..0x5 -> ras_ovf=1, ras_cnt=4. Pops yield 0x6,0x5,0x4,0x3. 5th pop -> pc=pc+1, ras_unf=1.
- Stall: stall=1 with ret and jmp asserted for 2 cycles -> pc, ras_cnt and flags unchanged. Deassert stall -> ret takes effect.
